line_buf_sched: RTL

- Ping-pong scheduler for the two one-line pixel buffers (buff0/buff1) in the deinterlacer datapath.
- Shares the buffers between the sink-side writer and the source-side reader; tracks per-buffer fill state, column counters and line age.
- Issues write/read enables and addresses, and decides when a single-line read or a paired (interpolation) read may start.
- Sits between the Avalon-ST sink/source FSMs and two WIDTH-deep synchronous RAMs.

---
 rtl/line_buf_sched_pkg.sv | 31 +++
 rtl/line_buf_sched_if.sv | 40 ++++
 rtl/line_buf_sched_col_ctr.sv | 42 ++++
 rtl/line_buf_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_sched_pkg.sv
// Shared types for the deinterlacer line-buffer scheduler: buffer fill states,
// writer/reader FSM states and the buffer count.
package line_buf_pkg;

    localparam int BUF_CNT = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } buf_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_SINGLE = 2'd1,
        R_PAIR   = 2'd2
    } rd_state_t;

    // Full-buffer count after an optional completed write and an optional release.
    function automatic logic [1:0] cnt_adj(input logic [1:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
        return cnt + {1'b0, inc} - {1'b0, dec};
    endfunction

endpackage

// File: rtl/line_buf_sched_if.sv
// Handshake/strobe bundle between the sink/source FSMs (master) and the
// line-buffer scheduler (slave).
interface line_buf_sched_if #(
    parameter int COL_W = 10
);
    logic             frame_start;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_en0;
    logic             wr_en1;
    logic [COL_W-1:0] wr_addr;
    logic             wr_line_done;
    logic             rd_start;
    logic             rd_pair;
    logic             rd_release;
    logic             rd_avail_single;
    logic             rd_avail_pair;
    logic             rd_busy;
    logic             rd_step;
    logic             rd_en0;
    logic             rd_en1;
    logic [COL_W-1:0] rd_addr;
    logic             rd_prim;
    logic             rd_line_done;

    modport master (
        output frame_start, wr_valid, rd_start, rd_pair, rd_release, rd_step,
        input  wr_ready, wr_en0, wr_en1, wr_addr, wr_line_done,
        input  rd_avail_single, rd_avail_pair, rd_busy, rd_en0, rd_en1,
        input  rd_addr, rd_prim, rd_line_done
    );

    modport slave (
        input  frame_start, wr_valid, rd_start, rd_pair, rd_release, rd_step,
        output wr_ready, wr_en0, wr_en1, wr_addr, wr_line_done,
        output rd_avail_single, rd_avail_pair, rd_busy, rd_en0, rd_en1,
        output rd_addr, rd_prim, rd_line_done
    );

endinterface

// File: rtl/line_buf_sched_col_ctr.sv
// Column counter for one side of the line buffers: counts enabled beats,
// wraps to zero after WIDTH-1 and flags the wrapping beat combinationally.
module line_col_ctr #(
    parameter int WIDTH = 640,
    parameter int COL_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] count,
    output logic             wrap
);

    localparam logic [COL_W-1:0] LAST = COL_W'(WIDTH - 1);

    logic [COL_W-1:0] count_reg;
    logic [COL_W-1:0] count_next;

    assign wrap  = en & (count_reg == LAST);
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/line_buf_sched.sv
// Ping-pong scheduler for the two one-line deinterlacer buffers.
// Define LINE_BUF_SCHED_ERR_EN to add sticky err_ovf/err_unf outputs.
module line_buf_sched
    import line_buf_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int COL_W = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    line_buf_sched_if.slave        bus
`ifdef LINE_BUF_SCHED_ERR_EN
    ,
    output logic                   err_ovf,
    output logic                   err_unf
`endif
);

    wr_state_t    wr_state_reg, wr_state_next;
    rd_state_t    rd_state_reg, rd_state_next;
    buf_state_t   buf_state_reg  [BUF_CNT];
    buf_state_t   buf_state_next [BUF_CNT];
    logic [1:0]   full_cnt_reg, full_cnt_next;
    logic         wr_ptr_reg, wr_ptr_next;
    logic         rd_ptr_reg, rd_ptr_next;
    logic         rd_release_reg, rd_release_next;
    logic         wr_line_done_reg, wr_line_done_next;
    logic         rd_line_done_reg, rd_line_done_next;

    logic             wr_ready;
    logic             wr_accept;
    logic             wr_wrap;
    logic             rd_idle;
    logic             avail_single;
    logic             avail_pair;
    logic             rd_accept;
    logic             rd_active;
    logic             rd_wrap;
    logic             rel_done;
    logic [COL_W-1:0] wr_col;
    logic [COL_W-1:0] rd_col;
    logic [BUF_CNT-1:0] wr_en;
    logic [BUF_CNT-1:0] rd_en;

    assign wr_ready     = (buf_state_reg[wr_ptr_reg] != FULL);
    assign wr_accept    = bus.wr_valid & wr_ready;
    assign rd_idle      = (rd_state_reg == R_IDLE);
    assign avail_single = rd_idle & (full_cnt_reg != 2'd0);
    assign avail_pair   = rd_idle & (full_cnt_reg == 2'd2);
    assign rd_accept    = bus.rd_start & (bus.rd_pair ? avail_pair : avail_single);
    assign rd_active    = bus.rd_step & ~rd_idle;
    assign rel_done     = rd_wrap & rd_release_reg;

    line_col_ctr #(.WIDTH(WIDTH), .COL_W(COL_W)) u_wr_ctr (
        .clock (clock),
        .reset (reset),
        .clr   (bus.frame_start),
        .en    (wr_accept),
        .count (wr_col),
        .wrap  (wr_wrap)
    );

    line_col_ctr #(.WIDTH(WIDTH), .COL_W(COL_W)) u_rd_ctr (
        .clock (clock),
        .reset (reset),
        .clr   (bus.frame_start),
        .en    (rd_active),
        .count (rd_col),
        .wrap  (rd_wrap)
    );

    // A single read strobes only the primary buffer; a paired read strobes both.
    genvar gi;
    generate
        for (gi = 0; gi < BUF_CNT; gi++) begin : g_buf
            localparam logic IDX = 1'(gi);
            assign wr_en[gi] = wr_accept & (wr_ptr_reg == IDX);
            assign rd_en[gi] = rd_active & ((rd_state_reg == R_PAIR) | (rd_ptr_reg == IDX));
        end
    endgenerate

    always_comb begin
        wr_state_next     = wr_state_reg;
        rd_state_next     = rd_state_reg;
        for (int i = 0; i < BUF_CNT; i++) begin
            buf_state_next[i] = buf_state_reg[i];
        end
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        rd_release_next   = rd_release_reg;
        wr_line_done_next = wr_wrap;
        rd_line_done_next = rd_wrap;
        full_cnt_next     = cnt_adj(full_cnt_reg, wr_wrap, rel_done);

        case (wr_state_reg)
            W_IDLE: begin
                if (wr_accept) begin
                    buf_state_next[wr_ptr_reg] = FILLING;
                    wr_state_next              = W_FILL;
                end
            end
            default: ;
        endcase
        if (wr_wrap) begin
            buf_state_next[wr_ptr_reg] = FULL;
            wr_ptr_next                = ~wr_ptr_reg;
            wr_state_next              = W_IDLE;
        end

        // Writer and reader always own different buffers, so a completion and
        // a release in the same cycle touch distinct entries.
        case (rd_state_reg)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_next   = bus.rd_pair ? R_PAIR : R_SINGLE;
                    rd_release_next = bus.rd_release;
                end
            end
            default: begin
                if (rd_wrap) begin
                    rd_state_next = R_IDLE;
                    if (rd_release_reg) begin
                        buf_state_next[rd_ptr_reg] = EMPTY;
                        rd_ptr_next                = ~rd_ptr_reg;
                    end
                end
            end
        endcase

        if (bus.frame_start) begin
            wr_state_next     = W_IDLE;
            rd_state_next     = R_IDLE;
            for (int i = 0; i < BUF_CNT; i++) begin
                buf_state_next[i] = EMPTY;
            end
            wr_ptr_next       = 1'b0;
            rd_ptr_next       = 1'b0;
            rd_release_next   = 1'b0;
            wr_line_done_next = 1'b0;
            rd_line_done_next = 1'b0;
            full_cnt_next     = 2'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_reg     <= W_IDLE;
            rd_state_reg     <= R_IDLE;
            for (int i = 0; i < BUF_CNT; i++) begin
                buf_state_reg[i] <= EMPTY;
            end
            full_cnt_reg     <= 2'd0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            rd_release_reg   <= 1'b0;
            wr_line_done_reg <= 1'b0;
            rd_line_done_reg <= 1'b0;
        end else begin
            wr_state_reg     <= wr_state_next;
            rd_state_reg     <= rd_state_next;
            for (int i = 0; i < BUF_CNT; i++) begin
                buf_state_reg[i] <= buf_state_next[i];
            end
            full_cnt_reg     <= full_cnt_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            rd_release_reg   <= rd_release_next;
            wr_line_done_reg <= wr_line_done_next;
            rd_line_done_reg <= rd_line_done_next;
        end
    end

`ifdef LINE_BUF_SCHED_ERR_EN
    logic err_ovf_reg, err_ovf_next;
    logic err_unf_reg, err_unf_next;

    always_comb begin
        err_ovf_next = err_ovf_reg | (bus.wr_valid & ~wr_ready);
        err_unf_next = err_unf_reg | (bus.rd_start & ~rd_accept) | (bus.rd_step & rd_idle);
        if (bus.frame_start) begin
            err_ovf_next = 1'b0;
            err_unf_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;
`endif

    assign bus.wr_ready        = wr_ready;
    assign bus.wr_en0          = wr_en[0];
    assign bus.wr_en1          = wr_en[1];
    assign bus.wr_addr         = wr_col;
    assign bus.wr_line_done    = wr_line_done_reg;
    assign bus.rd_avail_single = avail_single;
    assign bus.rd_avail_pair   = avail_pair;
    assign bus.rd_busy         = ~rd_idle;
    assign bus.rd_en0          = rd_en[0];
    assign bus.rd_en1          = rd_en[1];
    assign bus.rd_addr         = rd_col;
    assign bus.rd_prim         = rd_ptr_reg;
    assign bus.rd_line_done    = rd_line_done_reg;

endmodule
